// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - deskewing per-column accumulator bank with unified buffer drain (optional ReLU on drain: ACC_BANK_RELU_EN)
module acc_bank #(
    parameter int NUM_COLS = 2,
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic                       accumulate,
    input  logic [NUM_COLS*DATA_W-1:0] acc_in,
    input  logic                       drain_req,
    input  logic [ADDR_W-1:0]          ub_base,
    output logic                       ub_wr_valid,
    input  logic                       ub_wr_ready,
    output logic [ADDR_W-1:0]          ub_wr_addr,
    output logic [DATA_W-1:0]          ub_wr_data,
    output logic                       full,
    output logic                       done,
    output logic                       overflow
);

    localparam int TOTAL = NUM_COLS * DEPTH;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL, S_DRAIN} state_t;

    state_t              state_q;
    logic                tile_mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    beat_q;
    logic                wr_valid_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                full_q;
    logic                done_q;
    logic                overflow_q;

    // Entry storage is row-major: entry index = row * NUM_COLS + column.
    logic [DATA_W-1:0]   mem_q [TOTAL];
    logic [PTR_W-1:0]    ptr_q [NUM_COLS];

    logic                filling;
    logic                accept;
    logic                mode;
    logic [NUM_COLS-1:0] lane_vld;
    logic [NUM_COLS-1:0] we;
    logic                last_store;
    logic [DATA_W-1:0]   cur [NUM_COLS];
    logic [DATA_W-1:0]   wval [NUM_COLS];
    logic [IDX_W-1:0]    nxt_idx;
    logic                last_beat;
    logic [DATA_W-1:0]   drain_word;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_add = s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] post_proc(input logic [DATA_W-1:0] v);
`ifdef ACC_BANK_RELU_EN
        post_proc = v[DATA_W-1] ? '0 : v;
`else
        post_proc = v;
`endif
    endfunction

    assign filling     = (state_q == S_IDLE) || (state_q == S_FILL);
    assign accept      = valid && filling;
    // The first row of a tile is written while still in IDLE, before tile_mode_q is loaded.
    assign mode        = (state_q == S_IDLE) ? accumulate : tile_mode_q;
    assign lane_vld[0] = accept;

    generate
        if (NUM_COLS > 1) begin : g_skew
            logic [NUM_COLS-2:0] skew_q;

            // Delay the row strobe one cycle per column to match the array's diagonal wavefront.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    skew_q <= '0;
                end else begin
                    skew_q[0] <= accept;
                    for (int i = 1; i < NUM_COLS - 1; i++) begin
                        skew_q[i] <= skew_q[i-1];
                    end
                end
            end

            for (genvar c = 1; c < NUM_COLS; c++) begin : g_tap
                assign lane_vld[c] = skew_q[c-1];
            end
        end
    endgenerate

    // Per-lane write enable and write value: the addressed entry is read, then overwritten or summed.
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            cur[c] = '0;
            for (int r = 0; r < DEPTH; r++) begin
                if (ptr_q[c] == PTR_W'(r)) cur[c] = mem_q[r*NUM_COLS + c];
            end
            we[c]   = lane_vld[c] && filling && (ptr_q[c] != PTR_W'(DEPTH));
            wval[c] = mode ? sat_add(cur[c], acc_in[c*DATA_W +: DATA_W])
                           : acc_in[c*DATA_W +: DATA_W];
        end
        last_store = we[NUM_COLS-1] && (ptr_q[NUM_COLS-1] == PTR_W'(DEPTH - 1));
    end

    // Select the word for the next drain beat (beat 0 on drain accept, beat+1 while draining).
    always_comb begin
        nxt_idx    = (state_q == S_DRAIN) ? beat_q + IDX_W'(1) : '0;
        last_beat  = (beat_q == IDX_W'(TOTAL - 1));
        drain_word = '0;
        for (int e = 0; e < TOTAL; e++) begin
            if (nxt_idx == IDX_W'(e)) drain_word = post_proc(mem_q[e]);
        end
    end

    // Entry array and row pointers: lanes store independently, pointers rewind when a drain starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < TOTAL; e++) mem_q[e] <= '0;
            for (int c = 0; c < NUM_COLS; c++) ptr_q[c] <= '0;
        end else if (state_q == S_FULL && drain_req) begin
            for (int c = 0; c < NUM_COLS; c++) ptr_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (we[c]) begin
                    ptr_q[c] <= ptr_q[c] + PTR_W'(1);
                    for (int r = 0; r < DEPTH; r++) begin
                        if (ptr_q[c] == PTR_W'(r)) mem_q[r*NUM_COLS + c] <= wval[c];
                    end
                end
            end
        end
    end

    // Tile control FSM with registered full/done/overflow and the drain write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tile_mode_q <= 1'b0;
            base_q      <= '0;
            beat_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (valid && (state_q == S_FULL || state_q == S_DRAIN)) overflow_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        tile_mode_q <= accumulate;
                        if (last_store) begin
                            state_q <= S_FULL;
                            full_q  <= 1'b1;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (last_store) begin
                        state_q <= S_FULL;
                        full_q  <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (drain_req) begin
                        state_q    <= S_DRAIN;
                        full_q     <= 1'b0;
                        base_q     <= ub_base;
                        beat_q     <= '0;
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= ub_base;
                        wr_data_q  <= drain_word;
                    end
                end
                S_DRAIN: begin
                    if (ub_wr_ready) begin
                        if (last_beat) begin
                            state_q    <= S_IDLE;
                            wr_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            beat_q    <= nxt_idx;
                            wr_addr_q <= base_q + ADDR_W'(nxt_idx);
                            wr_data_q <= drain_word;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ub_wr_valid = wr_valid_q;
    assign ub_wr_addr  = wr_addr_q;
    assign ub_wr_data  = wr_data_q;
    assign full        = full_q;
    assign done        = done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_acc_bank.sv
// tb/tb_acc_bank.sv - scoreboard bench for acc_bank (default parameters)
module tb_acc_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        accumulate;
    logic [63:0] acc_in;
    logic        drain_req;
    logic [5:0]  ub_base;
    logic        ub_wr_valid;
    logic        ub_wr_ready;
    logic [5:0]  ub_wr_addr;
    logic [31:0] ub_wr_data;
    logic        full;
    logic        done;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0]  exp_addr [$];
    logic [31:0] exp_data [$];

    acc_bank dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .accumulate  (accumulate),
        .acc_in      (acc_in),
        .drain_req   (drain_req),
        .ub_base     (ub_base),
        .ub_wr_valid (ub_wr_valid),
        .ub_wr_ready (ub_wr_ready),
        .ub_wr_addr  (ub_wr_addr),
        .ub_wr_data  (ub_wr_data),
        .full        (full),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] post(input logic [31:0] v);
`ifdef ACC_BANK_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat that retires at the coming edge is checked against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && ub_wr_valid && ub_wr_ready) begin
                if (exp_addr.size() == 0) begin
                    chk("beat_unexpected", 32'(ub_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    chk("beat_addr", 32'(ub_wr_addr), 32'(exp_addr.pop_front()));
                    chk("beat_data", ub_wr_data, exp_data.pop_front());
                end
            end
        end
    end

    // Edge 0: lane0 row0; edge 1: lane0 row1 + lane1 row0; edge 2: lane1 row1.
    task automatic fill(input logic mode, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] b0, input logic [31:0] b1, input logic dr_in_fill);
        accumulate = mode;
        valid      = 1'b1;
        acc_in     = {32'd0, a0};
        step();
        chk("fill_e0_full", 32'(full), 32'd0);
        accumulate = ~mode;
        valid      = 1'b1;
        acc_in     = {b0, a1};
        drain_req  = dr_in_fill;
        step();
        chk("fill_e1_full", 32'(full), 32'd0);
        chk("fill_e1_wr_valid", 32'(ub_wr_valid), 32'd0);
        accumulate = 1'b0;
        valid      = 1'b0;
        drain_req  = 1'b0;
        acc_in     = {b1, 32'd0};
        step();
        chk("fill_e2_full", 32'(full), 32'd1);
        acc_in     = '0;
    endtask

    task automatic drain(input logic [5:0] base, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input int stall_beat, input int stall_cyc);
        logic [31:0] d [4];
        int cur;
        int stalled;
        int steps;
        bit seen;
        d[0] = post(d0);
        d[1] = post(d1);
        d[2] = post(d2);
        d[3] = post(d3);
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(base + 6'(i));
            exp_data.push_back(d[i]);
        end
        ub_base     = base;
        drain_req   = 1'b1;
        ub_wr_ready = 1'b1;
        step();
        drain_req = 1'b0;
        chk("drain_start_full", 32'(full), 32'd0);
        chk("drain_start_valid", 32'(ub_wr_valid), 32'd1);
        cur = 0;
        stalled = 0;
        steps = 0;
        seen = 1'b0;
        while (!seen && steps < 40) begin
            if (cur == stall_beat && stalled < stall_cyc) begin
                ub_wr_ready = 1'b0;
                stalled++;
            end else begin
                ub_wr_ready = 1'b1;
                cur++;
            end
            step();
            steps++;
            if (!ub_wr_ready) begin
                chk("hold_valid", 32'(ub_wr_valid), 32'd1);
                chk("hold_addr", 32'(ub_wr_addr), 32'(base + 6'(stall_beat)));
                chk("hold_data", ub_wr_data, d[stall_beat]);
            end
            if (done) seen = 1'b1;
        end
        chk("drain_cycles", 32'(steps), 32'(4 + stall_cyc));
        chk("drain_end_valid", 32'(ub_wr_valid), 32'd0);
        ub_wr_ready = 1'b1;
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        valid       = 1'b0;
        accumulate  = 1'b0;
        acc_in      = '0;
        drain_req   = 1'b0;
        ub_base     = '0;
        ub_wr_ready = 1'b0;
        step();
        step();
        chk("rst_wr_valid", 32'(ub_wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(ub_wr_addr), 32'd0);
        chk("rst_wr_data", ub_wr_data, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        step();

        // Tile 1: overwrite, then valid while FULL is dropped and flagged.
        fill(1'b0, 32'd5, 32'd7, 32'd11, 32'd13, 1'b0);
        chk("ovf_before", 32'(overflow), 32'd0);
        valid  = 1'b1;
        acc_in = {32'd99, 32'd99};
        step();
        valid  = 1'b0;
        acc_in = '0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_full_kept", 32'(full), 32'd1);
        drain(6'd62, 32'd5, 32'd11, 32'd7, 32'd13, -1, 0);

        // Tile 2: same data, beat 1 stalled three cycles.
        fill(1'b0, 32'd5, 32'd7, 32'd11, 32'd13, 1'b0);
        drain(6'd62, 32'd5, 32'd11, 32'd7, 32'd13, 1, 3);

        // Tile 3: accumulate ones onto the persisted entries.
        fill(1'b1, 32'd1, 32'd1, 32'd1, 32'd1, 1'b0);
        drain(6'd0, 32'd6, 32'd12, 32'd8, 32'd14, -1, 0);

        // Tile 4: extreme values, drain_req during FILL must be ignored.
        fill(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 1'b1);
        drain(6'd10, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'd2, -1, 0);

        // Tile 5: saturating accumulate at both rails plus ordinary sums.
        fill(1'b1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd5, 1'b0);
        drain(6'd30, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'd7, -1, 0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Tile 6: reset once beats 0 and 1 have retired.
        fill(1'b0, 32'd21, 32'd22, 32'd23, 32'd24, 1'b0);
        exp_addr.push_back(6'd20);
        exp_data.push_back(32'd21);
        exp_addr.push_back(6'd21);
        exp_data.push_back(32'd23);
        ub_base     = 6'd20;
        drain_req   = 1'b1;
        ub_wr_ready = 1'b1;
        step();
        drain_req = 1'b0;
        step();
        step();
        ub_wr_ready = 1'b0;
        reset       = 1'b1;
        #1;
        chk("mid_rst_wr_valid", 32'(ub_wr_valid), 32'd0);
        chk("mid_rst_wr_addr", 32'(ub_wr_addr), 32'd0);
        chk("mid_rst_wr_data", ub_wr_data, 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        step();
        reset = 1'b0;
        chk("mid_rst_beats_seen", 32'(exp_addr.size()), 32'd0);
        step();

        // Tile 7: accumulate onto cleared entries yields the raw inputs.
        fill(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
        drain(6'd0, 32'd1, 32'd3, 32'd2, 32'd4, -1, 0);

        step();
        chk("queue_empty", 32'(exp_addr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
